// File: rtl/pipe_pkg.sv
// pipe_pkg: shared constants, sizing helpers and handshake bundle
// for the elastic pipeline register.
package pipe_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_STAGES = 2;

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
  } hs_t;

  function automatic int capacity(input int stages);
    return 2 * stages;
  endfunction

  function automatic int cnt_w(input int stages);
    return $clog2(capacity(stages) + 1);
  endfunction

endpackage

// File: rtl/pipe_reg_if.sv
// pipe_reg_if: upstream and downstream valid/ready handshake
// of the elastic pipeline register.
interface pipe_reg_if #(
  parameter int WIDTH = pipe_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );

endinterface

// File: rtl/pipe_reg_skid_stage.sv
// skid_stage: one main+skid register pair; ready is taken from the
// registered skid state so out_ready never reaches in_ready.
module skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             m_valid_q, m_valid_d;
  logic [WIDTH-1:0] m_data_q, m_data_d;
  logic             s_valid_q, s_valid_d;
  logic [WIDTH-1:0] s_data_q, s_data_d;
  logic             accept;
  logic             take;

  assign in_ready  = !s_valid_q;
  assign out_valid = m_valid_q;
  assign out_data  = m_data_q;
  assign accept    = in_valid && !s_valid_q;
  assign take      = m_valid_q && out_ready;

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    s_valid_d = s_valid_q;
    s_data_d  = s_data_q;
    unique case (1'b1)
      take && s_valid_q: begin
        m_data_d  = s_data_q;
        s_valid_d = 1'b0;
      end
      take && !s_valid_q: begin
        m_valid_d = accept;
        if (accept) m_data_d = in_data;
      end
      !take && m_valid_q: begin
        if (accept) begin
          s_valid_d = 1'b1;
          s_data_d  = in_data;
        end
      end
      !m_valid_q: begin
        if (accept) begin
          m_valid_d = 1'b1;
          m_data_d  = in_data;
        end
      end
      default: ;
    endcase
    // data is deliberately kept on flush; only the valids drop
    if (flush) begin
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
    end else begin
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      s_valid_q <= s_valid_d;
      s_data_q  <= s_data_d;
    end
  end

endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: STAGES-deep elastic pipeline register with occupancy count.
// Define PIPE_REG_PERF_EN to add stall_cnt / xfer_cnt outputs.
module pipe_reg
  import pipe_pkg::*;
#(
  parameter  int WIDTH  = DEF_WIDTH,
  parameter  int STAGES = DEF_STAGES,
  localparam int CNT_W  = cnt_w(STAGES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  pipe_reg_if.slave        bus,
  output logic [CNT_W-1:0] occupancy
`ifdef PIPE_REG_PERF_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      xfer_cnt
`endif
);

  localparam int               CAP   = capacity(STAGES);
  localparam logic [CNT_W-1:0] CAP_W = CNT_W'(CAP);

  logic             vld [STAGES+1];
  logic             rdy [STAGES+1];
  logic [WIDTH-1:0] dat [STAGES+1];
  logic             in_fire;
  logic             out_fire;
  logic [CNT_W-1:0] occ_q, occ_d;

  assign vld[0]        = bus.in_valid;
  assign dat[0]        = bus.in_data;
  assign rdy[STAGES]   = bus.out_ready;
  // ready is held low for the whole reset, then follows the skid state
  assign bus.in_ready  = rdy[0] && !rst;
  assign bus.out_valid = vld[STAGES];
  assign bus.out_data  = dat[STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    skid_stage #(
      .WIDTH(WIDTH)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .flush    (flush),
      .in_valid (vld[i]),
      .in_ready (rdy[i]),
      .in_data  (dat[i]),
      .out_valid(vld[i+1]),
      .out_ready(rdy[i+1]),
      .out_data (dat[i+1])
    );
  end

  assign in_fire  = vld[0] && rdy[0] && !rst;
  assign out_fire = vld[STAGES] && rdy[STAGES];

  always_comb begin
    occ_d = occ_q;
    case ({in_fire, out_fire})
      2'b10: if (occ_q != CAP_W) occ_d = occ_q + 1'b1;
      2'b01: if (occ_q != '0) occ_d = occ_q - 1'b1;
      default: ;
    endcase
    if (flush) occ_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) occ_q <= '0;
    else     occ_q <= occ_d;
  end

  assign occupancy = occ_q;

`ifdef PIPE_REG_PERF_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] xfer_q, xfer_d;

  always_comb begin
    stall_d = stall_q;
    xfer_d  = xfer_q;
    if (vld[STAGES] && !rdy[STAGES] && stall_q != '1)
      stall_d = stall_q + 32'd1;
    if (out_fire && xfer_q != '1)
      xfer_d = xfer_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
      xfer_q  <= '0;
    end else begin
      stall_q <= stall_d;
      xfer_q  <= xfer_d;
    end
  end

  assign stall_cnt = stall_q;
  assign xfer_cnt  = xfer_q;
`endif

endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: scoreboard bench for pipe_reg (WIDTH=8, STAGES=2).
module tb_pipe_reg;

  bit         clk;
  logic       rst;
  logic       flush;
  logic [2:0] occupancy;
`ifdef PIPE_REG_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] xfer_cnt;
`endif

  int n_chk;
  int n_err;
  logic [7:0] q[$];

  pipe_reg_if #(.WIDTH(8)) bus ();

  pipe_reg #(
    .WIDTH (8),
    .STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .bus      (bus),
    .occupancy(occupancy)
`ifdef PIPE_REG_PERF_EN
    ,
    .stall_cnt(stall_cnt),
    .xfer_cnt (xfer_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // model: queue of accepted words, updated for the coming edge
  always @(negedge clk) begin
    chk("occ", 32'(occupancy), q.size());
    if (!rst) begin
      if (q.size() == 0) chk("empty_ov", 32'(bus.out_valid), 0);
      if (q.size() == 4) chk("full_ir", 32'(bus.in_ready), 0);
    end
    if (rst) begin
      q.delete();
    end else begin
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) chk("spurious", 32'(bus.out_valid), 0);
        else chk("data", 32'(bus.out_data), 32'(q.pop_front()));
      end
      if (flush) q.delete();
      else if (bus.in_valid && bus.in_ready) q.push_back(bus.in_data);
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    flush = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    bit done;
    int n;
    done = 0;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    while (!done) begin
      @(negedge clk);
      done = bus.in_ready;
      n++;
      if (!done && n > 200) begin
        chk("push_to", 32'(bus.in_ready), 1);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      #1;
      done = (q.size() == 0) && (occupancy == 0) && !bus.out_valid;
    end
    chk("drain", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  bit rand_run;

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("rst_ir", 32'(bus.in_ready), 0);
    do_reset();
    @(negedge clk);
    chk("rst_ov", 32'(bus.out_valid), 0);
    chk("rst_od", 32'(bus.out_data), 0);
    chk("rst_occ", 32'(occupancy), 0);
    chk("rst_ir1", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;

    // stream 0x01..0x10 at full rate
    bus.out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = 8'(i);
      @(negedge clk);
      chk("str_ir", 32'(bus.in_ready), 1);
      if (i == 2) chk("lat_0", 32'(bus.out_valid), 0);
      if (i == 3) chk("lat_1", 32'(bus.out_valid), 1);
      if (i == 10) chk("str_occ", 32'(occupancy), 2);
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    drain();

    // back-pressure fill
    begin
      int acc;
      acc = 0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
        bus.in_valid = 1'b1;
        bus.in_data = 8'hA0 + 8'(acc);
        @(negedge clk);
        if (bus.in_ready) acc++;
        @(posedge clk);
        #1;
      end
      bus.in_valid = 1'b0;
      chk("bp_acc", acc, 4);
      @(negedge clk);
      chk("bp_ir", 32'(bus.in_ready), 0);
      chk("bp_occ", 32'(occupancy), 4);
      @(posedge clk);
      #1;
      drain();
    end

    // random valid/ready
    rand_run = 1;
    fork
      begin
        for (int k = 0; k < 1000; k++) begin
          while ($urandom_range(1) == 0) begin
            @(posedge clk);
            #1;
          end
          push(8'($urandom));
        end
        rand_run = 0;
      end
      begin
        while (rand_run) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(1));
        end
      end
    join
    drain();

    // flush at occupancy 3 with a word arriving
    bus.out_ready = 1'b0;
    push(8'h30);
    push(8'h31);
    push(8'h32);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h55;
    @(negedge clk);
    chk("fl_occ3", 32'(occupancy), 3);
    @(posedge clk);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("fl_ov", 32'(bus.out_valid), 0);
    chk("fl_occ", 32'(occupancy), 0);
    chk("fl_ir", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    push(8'h66);
    begin
      bit seen;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
        @(negedge clk);
        seen = bus.out_valid;
      end
      chk("fl_next", 32'(bus.out_data), 32'h66);
    end
    drain();

    // reset mid-stream with the pipe full
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) push(8'h70 + 8'(i));
    rst = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data = 8'h99;
    @(negedge clk);
    chk("mr_ir0", 32'(bus.in_ready), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("mr_ov", 32'(bus.out_valid), 0);
    chk("mr_od", 32'(bus.out_data), 0);
    chk("mr_occ", 32'(occupancy), 0);
    chk("mr_ir", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    push(8'h42);
    drain();

`ifdef PIPE_REG_PERF_EN
    bus.out_ready = 1'b0;
    do_reset();
    push(8'h11);
    push(8'h12);
    push(8'h13);
    repeat (4) @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    @(negedge clk);
    chk("stall", stall_cnt, 5);
    chk("xfer", xfer_cnt, 3);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    chk("stall_fl", stall_cnt, 5);
    chk("xfer_fl", xfer_cnt, 3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pipe_reg.md
Name: pipe_reg

Overview:
- Parametrised elastic pipeline register: the next generation of the plain load-enable register used across the RISC datapath.
- Replaces load-enable with a valid/ready handshake.
- STAGES deep, with a skid buffer per stage so full throughput is kept without a combinational ready path through the chain.
- Sits between datapath units (e.g. fetch->decode, ALU->writeback), where back-pressure and flush on branch are required.

Parameters:
- WIDTH, 8, payload width in bits (>=1)
- STAGES, 2, number of pipeline stages (>=1); total capacity 2*STAGES words
- CNT_W, $clog2(2*STAGES+1), occupancy counter width (derived, not overridden)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous active-high reset
- flush  in  1  synchronous discard of all buffered words
- in_valid  in  1  upstream word valid
- in_ready  out  1  pipe can accept a word
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  word available at output
- out_ready  in  1  downstream accepts word
- out_data  out  WIDTH  output payload
- occupancy  out  CNT_W  number of words currently held (0..2*STAGES)

Behaviour:
- Transfer rules:
  - Input transfer when in_valid && in_ready at posedge.
  - Output transfer when out_valid && out_ready at posedge.
- Each stage holds a main register (m_valid, m_data) and a skid register (s_valid, s_data).
  - Stage ready to its upstream = !s_valid. This is registered, so no combinational path runs from out_ready to in_ready.
  - Stage 0 feeds from in_*; stage STAGES-1 drives out_*.
  - out_valid = m_valid of the last stage; out_data = its m_data.
- Stage update per cycle:
  - Downstream takes main and skid full: skid moves to main, skid empties.
  - Downstream takes main, skid empty: main loads the incoming word if any, else main empties.
  - Downstream does not take, main full, word arrives: word goes to skid. Only possible when s_valid=0.
  - Main empty: the incoming word goes directly to main.
- Latency: a word accepted at edge N with an empty pipe and out_ready=1 gives out_valid=1 in the cycle after edge N+STAGES-1, i.e. STAGES cycles of latency.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Ordering: strict FIFO; no word is dropped or duplicated.
- Full: all 2*STAGES registers valid -> in_ready=0. in_valid with in_ready=0 is ignored. in_data need not be held stable by this block's rules, but the upstream keeps it stable per protocol.
- Empty: out_valid=0. out_data holds its last value and is don't-care for checking.
- occupancy:
  - Increments on input transfer, decrements on output transfer, unchanged when both occur.
  - Never exceeds 2*STAGES and never wraps.
- Flush:
  - Asserted at edge N: all m_valid/s_valid clear at N and occupancy becomes 0.
  - An input transfer coinciding with flush is discarded; an output transfer coinciding with flush still completes.
  - in_ready=1 in the cycle after.
  - Data registers are not cleared.
- Reset:
  - All valids=0, all data registers=0, occupancy=0, out_valid=0, out_data=0.
  - in_ready=0 while rst=1 and 1 in the first cycle after deassert.
  - rst has priority over flush and over any transfer.
  - Reset mid-stream discards all words.
- Upstream must not retract in_valid before a transfer. Downstream may toggle out_ready freely.

Optional Feature:
- Macro PIPE_REG_PERF_EN.
- When defined:
  - Adds outputs stall_cnt (32 bits) and xfer_cnt (32 bits).
  - stall_cnt increments each cycle with out_valid && !out_ready.
  - xfer_cnt increments per output transfer.
  - Both saturate at 2^32-1 and clear on rst only; flush does not clear them.
- When undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package pipe_pkg:
  - Default WIDTH/STAGES constants.
  - Function returning the capacity 2*STAGES and the CNT_W derivation.
  - Handshake bundle typedef (valid, data).
- One sub-module, skid_stage: one main+skid stage with WIDTH parameter, flush, rst.
- pipe_reg instantiates STAGES copies via generate and owns the occupancy counter and the perf counters.

Test Plan:
- Reset then stream: WIDTH=8, STAGES=2, push 0x01..0x10 with out_ready=1 -> first out_valid 2 cycles after first accept; outputs 0x01..0x10 in order, one per cycle; occupancy settles at 2.
- Back-pressure fill: out_ready=0, push continuously -> exactly 4 words accepted (0xA0..0xA3), in_ready=0 from then, occupancy=4; release out_ready -> 0xA0..0xA3 out in order.
- Random valid/ready at 50% each for 1000 words -> scoreboard exact order match; occupancy always equals accepted minus delivered and stays within 0..4.
- Flush when occupancy=3 with a simultaneous input word 0x55 -> next cycle out_valid=0, occupancy=0, 0x55 never appears; next word 0x66 pushed is the next output.
- Reset mid-stream at occupancy=4 -> after rst deassert out_valid=0, out_data=0x00, occupancy=0, in_ready=1; old words never appear.
- PIPE_REG_PERF_EN defined, 5 stall cycles then 3 transfers -> stall_cnt=5, xfer_cnt=3; flush leaves both unchanged.
